// File: rtl/clkdiv_pkg.sv
// Shared definitions for the clock divider bank.
//   CLKDIV_TOGGLE / CLKDIV_TICK : output mode encodings for cfg_mode_i
//   clog2_min1()                : address width helper, never returns less than 1
package clkdiv_pkg;

    localparam logic CLKDIV_TOGGLE = 1'b0;
    localparam logic CLKDIV_TICK   = 1'b1;

    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider / tick generator channel.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   en_i           : run enable; when low count and oclk freeze, tick stays low
//   wr_i           : config write strobe for this channel (half_i, mode_i)
//   restart_i      : phase-align restart, overrides everything but reset
//   oclk_o         : divided square output (TOGGLE mode), 0 in TICK mode
//   tick_o         : one-cycle pulse at each terminal count
//   pending_o      : shadow config written but not yet applied
module clk_div_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned      CNT_W    = 27,
    parameter logic [CNT_W-1:0] DEF_HALF = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] half_i,
    input  logic             mode_i,
    input  logic             restart_i,
    output logic             oclk_o,
    output logic             tick_o,
    output logic             pending_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_half_q, act_half_d;
    logic [CNT_W-1:0] sh_half_q, sh_half_d;
    logic             act_mode_q, act_mode_d;
    logic             sh_mode_q, sh_mode_d;
    logic             pend_q, pend_d;
    logic             oclk_q, oclk_d;
    logic             tick_q, tick_d;

    logic             tc;
    logic [CNT_W-1:0] nxt_half;
    logic             nxt_mode;

    assign tc = en_i && (cnt_q == '0);

    // Configuration in force after a terminal count; uses the shadow as it was
    // before any write landing on the same cycle.
    assign nxt_half = pend_q ? sh_half_q : act_half_q;
    assign nxt_mode = pend_q ? sh_mode_q : act_mode_q;

    always_comb begin
        cnt_d      = cnt_q;
        act_half_d = act_half_q;
        act_mode_d = act_mode_q;
        sh_half_d  = sh_half_q;
        sh_mode_d  = sh_mode_q;
        pend_d     = pend_q;
        oclk_d     = oclk_q;
        tick_d     = 1'b0;

        if (restart_i) begin
            // A write on the restart cycle is merged first so the restart uses it.
            if (wr_i) begin
                sh_half_d = half_i;
                sh_mode_d = mode_i;
            end
            act_half_d = sh_half_d;
            act_mode_d = sh_mode_d;
            cnt_d      = sh_half_d;
            oclk_d     = 1'b0;
            pend_d     = 1'b0;
        end else begin
            if (tc) begin
                act_half_d = nxt_half;
                act_mode_d = nxt_mode;
                cnt_d      = nxt_half;
                pend_d     = 1'b0;
                tick_d     = 1'b1;
                oclk_d     = (nxt_mode == CLKDIV_TICK) ? 1'b0 : ~oclk_q;
            end else if (en_i) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (wr_i) begin
                sh_half_d = half_i;
                sh_mode_d = mode_i;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= DEF_HALF;
            act_half_q <= DEF_HALF;
            act_mode_q <= CLKDIV_TOGGLE;
            sh_half_q  <= DEF_HALF;
            sh_mode_q  <= CLKDIV_TOGGLE;
            pend_q     <= 1'b0;
            oclk_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_half_q <= act_half_d;
            act_mode_q <= act_mode_d;
            sh_half_q  <= sh_half_d;
            sh_mode_q  <= sh_mode_d;
            pend_q     <= pend_d;
            oclk_q     <= oclk_d;
            tick_q     <= tick_d;
        end
    end

    assign oclk_o    = oclk_q;
    assign tick_o    = tick_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of NUM_CH independent, runtime-programmable clock dividers.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   en_i             : per-channel run enable
//   cfg_wr_i         : one-cycle config write strobe, addressed by cfg_ch_i
//   cfg_half_i       : new half-period H (TC every H+1 cycles)
//   cfg_mode_i       : 0 = TOGGLE square wave, 1 = TICK pulse
//   sync_restart_i   : restart every channel in phase from its shadow config
//   oclk_o           : divided square outputs
//   tick_o           : terminal-count pulses
//   cfg_pending_o    : per-channel shadow config awaiting the next TC
module clk_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int unsigned              NUM_CH   = 2,
    parameter int unsigned              CNT_W    = 27,
    parameter logic [NUM_CH*CNT_W-1:0]  DEF_HALF = {27'd9999999, 27'd24999999},
    parameter int unsigned              CH_W     = clog2_min1(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              cfg_wr_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_half_i,
    input  logic              cfg_mode_i,
    input  logic              sync_restart_i,
    output logic [NUM_CH-1:0] oclk_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] cfg_pending_o
);

    logic [NUM_CH-1:0] wr_sel;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Addresses at or above NUM_CH match no channel and are dropped.
        assign wr_sel[i] = cfg_wr_i && (cfg_ch_i == CH_W'(i));

        clk_div_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .en_i      (en_i[i]),
            .wr_i      (wr_sel[i]),
            .half_i    (cfg_half_i),
            .mode_i    (cfg_mode_i),
            .restart_i (sync_restart_i),
            .oclk_o    (oclk_o[i]),
            .tick_o    (tick_o[i]),
            .pending_o (cfg_pending_o[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
module tb_clk_divider_bank;

    logic       clk;
    logic       rst_ni;
    logic [1:0] en;
    logic       cfg_wr;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_half;
    logic       cfg_mode;
    logic       sync_restart;
    logic [1:0] oclk;
    logic [1:0] tick;
    logic [1:0] cfg_pending;

    int n_checks;
    int n_errors;

    clk_divider_bank #(
        .NUM_CH   (2),
        .CNT_W    (8),
        .DEF_HALF ({8'd1, 8'd3})
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .en_i           (en),
        .cfg_wr_i       (cfg_wr),
        .cfg_ch_i       (cfg_ch),
        .cfg_half_i     (cfg_half),
        .cfg_mode_i     (cfg_mode),
        .sync_restart_i (sync_restart),
        .oclk_o         (oclk),
        .tick_o         (tick),
        .cfg_pending_o  (cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and sample 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit i holds the value seen after the (i+1)-th edge.
    task automatic capture(input int n, output logic [7:0] o0, output logic [7:0] t0,
                           output logic [7:0] o1, output logic [7:0] t1);
        o0 = '0; t0 = '0; o1 = '0; t1 = '0;
        for (int i = 0; i < n; i++) begin
            step(1);
            o0[i] = oclk[0];
            t0[i] = tick[0];
            o1[i] = oclk[1];
            t1[i] = tick[1];
        end
    endtask

    // Edges until oclk[ch] changes level, bounded.
    task automatic measure(input int ch, output int n);
        logic prev;
        prev = oclk[ch];
        n = 0;
        do begin
            step(1);
            n++;
        end while (oclk[ch] == prev && n < 50);
    endtask

    initial begin
        logic [7:0] o0, t0, o1, t1;
        logic       all_hi, any_tick;
        int         n;

        n_checks     = 0;
        n_errors     = 0;
        rst_ni       = 1'b0;
        en           = 2'b11;
        cfg_wr       = 1'b0;
        cfg_ch       = '0;
        cfg_half     = '0;
        cfg_mode     = 1'b0;
        sync_restart = 1'b0;

        // 1. Reset state and default division
        step(3);
        check_eq("rst_oclk", 32'(oclk), 32'h0);
        check_eq("rst_tick", 32'(tick), 32'h0);
        check_eq("rst_pending", 32'(cfg_pending), 32'h0);
        rst_ni = 1'b1;
        capture(8, o0, t0, o1, t1);
        check_eq("s1_oclk0", 32'(o0), 32'h78);
        check_eq("s1_tick0", 32'(t0), 32'h88);
        check_eq("s1_oclk1", 32'(o1), 32'h66);
        check_eq("s1_tick1", 32'(t1), 32'hAA);

        // 2. Mid-period reprogram of ch0 to H=5
        step(1);
        cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd5; cfg_mode = 1'b0;
        step(1);
        cfg_wr = 1'b0;
        check_eq("s2_pend_a", 32'(cfg_pending[0]), 32'h1);
        step(1);
        check_eq("s2_pend_b", 32'(cfg_pending[0]), 32'h1);
        check_eq("s2_oclk_hold", 32'(oclk[0]), 32'h0);
        step(1);
        check_eq("s2_oclk_tc", 32'(oclk[0]), 32'h1);
        check_eq("s2_pend_clr", 32'(cfg_pending[0]), 32'h0);
        measure(0, n);
        check_eq("s2_half_a", 32'(n), 32'd6);
        measure(0, n);
        check_eq("s2_half_b", 32'(n), 32'd6);

        // 3. ch1 to TICK mode, H=2
        cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd2; cfg_mode = 1'b1;
        step(1);
        cfg_wr = 1'b0;
        check_eq("s3_pend", 32'(cfg_pending[1]), 32'h1);
        step(1);
        check_eq("s3_pend_clr", 32'(cfg_pending[1]), 32'h0);
        check_eq("s3_oclk1", 32'(oclk[1]), 32'h0);
        check_eq("s3_tick1", 32'(tick[1]), 32'h1);
        capture(6, o0, t0, o1, t1);
        check_eq("s3_oclk1_seq", 32'(o1), 32'h00);
        check_eq("s3_tick1_seq", 32'(t1), 32'h24);

        // 4. Freeze ch0 for 10 cycles while oclk[0] is high
        step(5);
        check_eq("s4_pre", 32'(oclk[0]), 32'h1);
        en = 2'b10;
        all_hi   = 1'b1;
        any_tick = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            all_hi   = all_hi & oclk[0];
            any_tick = any_tick | tick[0];
        end
        check_eq("s4_frz_oclk", 32'(all_hi), 32'h1);
        check_eq("s4_frz_tick", 32'(any_tick), 32'h0);
        en = 2'b11;
        measure(0, n);
        check_eq("s4_resume", 32'(n), 32'd5);

        // 5. sync_restart merged with a ch0 H=0 write
        sync_restart = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd0; cfg_mode = 1'b0;
        step(1);
        sync_restart = 1'b0;
        cfg_wr = 1'b0;
        check_eq("s5_oclk", 32'(oclk), 32'h0);
        check_eq("s5_tick", 32'(tick), 32'h0);
        check_eq("s5_pend", 32'(cfg_pending), 32'h0);
        step(1);
        check_eq("s5_oclk0_a", 32'(oclk[0]), 32'h1);
        check_eq("s5_tick0_a", 32'(tick[0]), 32'h1);
        step(1);
        check_eq("s5_oclk0_b", 32'(oclk[0]), 32'h0);
        check_eq("s5_tick1_b", 32'(tick[1]), 32'h0);
        // Write ch1 on the cycle of its terminal count: must stay pending.
        cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd7; cfg_mode = 1'b0;
        step(1);
        cfg_wr = 1'b0;
        check_eq("s5_tick1_c", 32'(tick[1]), 32'h1);
        check_eq("s5_oclk1_c", 32'(oclk[1]), 32'h0);
        check_eq("s5_pend_tc", 32'(cfg_pending[1]), 32'h1);

        // 6. Asynchronous reset mid-period, then default behaviour again
        #1;
        rst_ni = 1'b0;
        #1;
        check_eq("s6_oclk", 32'(oclk), 32'h0);
        check_eq("s6_tick", 32'(tick), 32'h0);
        check_eq("s6_pend", 32'(cfg_pending), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        capture(8, o0, t0, o1, t1);
        check_eq("s6_oclk0", 32'(o0), 32'h78);
        check_eq("s6_tick0", 32'(t0), 32'h88);
        check_eq("s6_oclk1", 32'(o1), 32'h66);
        check_eq("s6_tick1", 32'(t1), 32'hAA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
